// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and sizing for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

  localparam int RSLEN    = 16;
  localparam int ISSUE_W  = 3;
  localparam int CDB_W    = 3;
  localparam int NUM_ALU  = 3;
  localparam int MULT_LAT = 4;
  localparam int IDX_W    = $clog2(RSLEN);
  localparam int FU_W     = 2;
  localparam int CNT_W    = IDX_W + 1;
  localparam int SLOT_W   = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  typedef enum logic [FU_W-1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_MEM  = 2'd2,
    FU_BR   = 2'd3
  } fu_type_e;

  // CDB slots left for single-cycle (ALU/BR) results, floored at zero.
  function automatic logic [CNT_W-1:0] cdb_budget(input logic mult_due_i, input logic ls_done_i);
    logic [CNT_W-1:0] used;
    used = CNT_W'(mult_due_i) + CNT_W'(ls_done_i);
    if (used >= CNT_W'(CDB_W)) begin
      return '0;
    end else begin
      return CNT_W'(CDB_W) - used;
    end
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_select.sv
// Rotating, capacity-limited pick over the RS entries.
module rs_issue_scheduler_select
  import rs_issue_scheduler_pkg::*;
(
  input  logic [RSLEN-1:0]            req,
  input  logic [RSLEN-1:0][FU_W-1:0]  fu_type,
  input  logic [IDX_W-1:0]            rr_ptr,
  input  logic [3:0][CNT_W-1:0]       class_limit,
  input  logic [CNT_W-1:0]            single_budget,
  output logic [RSLEN-1:0]            grant,
  output logic                        any_grant,
  output logic [IDX_W-1:0]            last_idx
);

  logic [3:0][CNT_W-1:0] class_cnt_s;
  logic [CNT_W-1:0]      total_s;
  logic [CNT_W-1:0]      single_s;
  logic [IDX_W-1:0]      ent_s;
  fu_type_e              cls_s;
  logic                  take_s;
  logic                  is_single_s;

  // Scan from rr_ptr with wraparound, granting while slot, class and CDB limits allow.
  always_comb begin
    grant       = '0;
    any_grant   = 1'b0;
    last_idx    = '0;
    class_cnt_s = '0;
    total_s     = '0;
    single_s    = '0;
    ent_s       = '0;
    cls_s       = FU_ALU;
    take_s      = 1'b0;
    is_single_s = 1'b0;
    for (int i = 0; i < RSLEN; i++) begin
      ent_s       = rr_ptr + IDX_W'(i);
      cls_s       = fu_type_e'(fu_type[ent_s]);
      is_single_s = (cls_s == FU_ALU) || (cls_s == FU_BR);
      take_s      = 1'b0;
      if (req[ent_s] && (total_s < CNT_W'(ISSUE_W)) && (class_cnt_s[cls_s] < class_limit[cls_s])) begin
        case (cls_s)
          FU_ALU, FU_BR:   take_s = (single_s < single_budget);
          FU_MULT, FU_MEM: take_s = 1'b1;
          default:         take_s = 1'b0;
        endcase
      end else begin
        take_s = 1'b0;
      end
      grant[ent_s]       = take_s;
      class_cnt_s[cls_s] = class_cnt_s[cls_s] + CNT_W'(take_s);
      total_s            = total_s + CNT_W'(take_s);
      single_s           = single_s + CNT_W'(take_s & is_single_s);
      any_grant          = any_grant | take_s;
      last_idx           = take_s ? ent_s : last_idx;
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Issue-select controller: picks up to ISSUE_W ready RS entries per cycle.
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          squash_flag,
  input  logic                          issue_stall,
  input  logic [RSLEN-1:0]              rs_ready,
  input  logic [RSLEN-1:0][FU_W-1:0]    rs_fu_type,
  input  logic                          ls_done,
  output logic [ISSUE_W-1:0]            issue_valid,
  output logic [ISSUE_W-1:0][IDX_W-1:0] issue_idx,
  output logic [ISSUE_W-1:0][FU_W-1:0]  issue_fu,
  output logic [RSLEN-1:0]              clear_mask,
  output logic                          ls_busy,
  output logic                          mult_due
);

  logic [IDX_W-1:0]      rr_ptr_r;
  logic                  ls_busy_r;
  logic [MULT_LAT-2:0]   mult_pipe_r;
  logic [MULT_LAT-2:0]   mult_next_s;

  logic                  issue_en_s;
  logic [RSLEN-1:0]      req_s;
  logic [3:0][CNT_W-1:0] class_limit_s;
  logic [CNT_W-1:0]      budget_s;
  logic [RSLEN-1:0]      grant_s;
  logic                  any_grant_s;
  logic [IDX_W-1:0]      last_idx_s;
  logic [RSLEN-1:0]      mult_mask_s;
  logic [RSLEN-1:0]      mem_mask_s;
  logic                  mult_g_s;
  logic                  mem_g_s;
  logic [SLOT_W-1:0]     slot_s;
  logic [IDX_W-1:0]      ent_s;

  assign issue_en_s = ~(reset | issue_stall | squash_flag);
  assign req_s      = rs_ready & {RSLEN{issue_en_s}};
  assign budget_s   = cdb_budget(mult_pipe_r[0], ls_done);

  // Per-class grant limits; the LS unit is non-pipelined, so MEM is closed while busy.
  always_comb begin
    class_limit_s          = '0;
    class_limit_s[FU_ALU]  = CNT_W'(NUM_ALU);
    class_limit_s[FU_MULT] = CNT_W'(1);
    class_limit_s[FU_BR]   = CNT_W'(1);
    class_limit_s[FU_MEM]  = ls_busy_r ? CNT_W'(0) : CNT_W'(1);
  end

  rs_issue_scheduler_select u_select (
    .req           (req_s),
    .fu_type       (rs_fu_type),
    .rr_ptr        (rr_ptr_r),
    .class_limit   (class_limit_s),
    .single_budget (budget_s),
    .grant         (grant_s),
    .any_grant     (any_grant_s),
    .last_idx      (last_idx_s)
  );

  // Class masks used to detect MULT and MEM grants for the sequential state.
  always_comb begin
    mult_mask_s = '0;
    mem_mask_s  = '0;
    for (int e = 0; e < RSLEN; e++) begin
      mult_mask_s[e] = (rs_fu_type[e] == FU_MULT);
      mem_mask_s[e]  = (rs_fu_type[e] == FU_MEM);
    end
  end

  assign mult_g_s = |(grant_s & mult_mask_s);
  assign mem_g_s  = |(grant_s & mem_mask_s);

  // Pack granted entries into issue slots in rotating scan order.
  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    issue_fu    = '0;
    slot_s      = '0;
    ent_s       = '0;
    for (int i = 0; i < RSLEN; i++) begin
      ent_s               = rr_ptr_r + IDX_W'(i);
      issue_valid[slot_s] = issue_valid[slot_s] | grant_s[ent_s];
      issue_idx[slot_s]   = grant_s[ent_s] ? ent_s : issue_idx[slot_s];
      issue_fu[slot_s]    = grant_s[ent_s] ? rs_fu_type[ent_s] : issue_fu[slot_s];
      slot_s              = slot_s + SLOT_W'(grant_s[ent_s]);
    end
  end

  assign clear_mask = grant_s;

  generate
    if (MULT_LAT == 2) begin : g_pipe_one
      assign mult_next_s = mult_g_s;
    end else begin : g_pipe_many
      assign mult_next_s = {mult_g_s, mult_pipe_r[MULT_LAT-2:1]};
    end
  endgenerate

  // Round-robin pointer, LS-unit occupancy and multiplier writeback pipe.
  always_ff @(posedge clock) begin
    if (reset || squash_flag) begin
      rr_ptr_r    <= '0;
      ls_busy_r   <= 1'b0;
      mult_pipe_r <= '0;
    end else begin
      rr_ptr_r    <= any_grant_s ? (last_idx_s + IDX_W'(1)) : rr_ptr_r;
      mult_pipe_r <= mult_next_s;
      if (mem_g_s) begin
        ls_busy_r <= 1'b1;
      end else if (ls_done) begin
        ls_busy_r <= 1'b0;
      end else begin
        ls_busy_r <= ls_busy_r;
      end
    end
  end

  assign ls_busy  = ls_busy_r;
  assign mult_due = mult_pipe_r[0];

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural issue model.
module tb_rs_issue_scheduler;
  import rs_issue_scheduler_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                          reset = 1'b1;
  logic                          squash_flag = 1'b0;
  logic                          issue_stall = 1'b0;
  logic                          ls_done = 1'b0;
  logic [RSLEN-1:0]              rs_ready = '0;
  logic [RSLEN-1:0][FU_W-1:0]    rs_fu_type = '0;
  logic [ISSUE_W-1:0]            issue_valid;
  logic [ISSUE_W-1:0][IDX_W-1:0] issue_idx;
  logic [ISSUE_W-1:0][FU_W-1:0]  issue_fu;
  logic [RSLEN-1:0]              clear_mask;
  logic                          ls_busy;
  logic                          mult_due;

  rs_issue_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .squash_flag (squash_flag),
    .issue_stall (issue_stall),
    .rs_ready    (rs_ready),
    .rs_fu_type  (rs_fu_type),
    .ls_done     (ls_done),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_fu    (issue_fu),
    .clear_mask  (clear_mask),
    .ls_busy     (ls_busy),
    .mult_due    (mult_due)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state: pointer, LS occupancy, cycles at which a mult result is due.
  int m_ptr = 0;
  bit m_busy = 1'b0;
  bit m_known = 1'b0;
  int due_q[$];
  int cyc = 0;

  // Expected outputs for the current cycle and decisions for the coming edge.
  bit               e_valid[ISSUE_W];
  int               e_idx[ISSUE_W];
  int               e_fu[ISSUE_W];
  logic [RSLEN-1:0] e_clear;
  bit               e_mdue;
  int               n_ptr;
  bit               mult_g;
  bit               mem_g;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_eval();
    int cnt[4];
    int tot, single, budget, last, e, f;
    bit ok;
    for (int k = 0; k < ISSUE_W; k++) begin
      e_valid[k] = 1'b0;
      e_idx[k]   = 0;
      e_fu[k]    = 0;
    end
    e_clear = '0;
    mult_g  = 1'b0;
    mem_g   = 1'b0;
    n_ptr   = m_ptr;
    e_mdue  = 1'b0;
    foreach (due_q[j]) if (due_q[j] == cyc) e_mdue = 1'b1;
    if (!reset && !issue_stall && !squash_flag) begin
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      tot = 0; single = 0; last = -1;
      budget = CDB_W - int'(e_mdue) - int'(ls_done);
      if (budget < 0) budget = 0;
      for (int i = 0; i < RSLEN; i++) begin
        e = (m_ptr + i) % RSLEN;
        f = int'(rs_fu_type[e]);
        ok = 1'b0;
        if (rs_ready[e] && tot < ISSUE_W) begin
          case (f)
            0:       ok = (cnt[0] < NUM_ALU) && (single < budget);
            1:       ok = (cnt[1] < 1);
            2:       ok = (cnt[2] < 1) && !m_busy;
            default: ok = (cnt[3] < 1) && (single < budget);
          endcase
        end
        if (ok) begin
          e_valid[tot] = 1'b1;
          e_idx[tot]   = e;
          e_fu[tot]    = f;
          e_clear[e]   = 1'b1;
          tot++;
          cnt[f]++;
          if (f == 0 || f == 3) single++;
          last = e;
        end
      end
      if (tot > 0) n_ptr = (last + 1) % RSLEN;
      mult_g = (cnt[1] > 0);
      mem_g  = (cnt[2] > 0);
    end
  endtask

  task automatic model_commit();
    if (reset || squash_flag) begin
      m_ptr  = 0;
      m_busy = 1'b0;
      due_q.delete();
    end else begin
      m_ptr = n_ptr;
      if (mem_g) m_busy = 1'b1;
      else if (ls_done) m_busy = 1'b0;
      if (mult_g) due_q.push_back(cyc + MULT_LAT - 1);
    end
    if (reset) m_known = 1'b1;
    due_q = due_q.find(x) with (x > cyc);
    cyc++;
  endtask

  task automatic compare();
    for (int k = 0; k < ISSUE_W; k++) begin
      chk("issue_valid", issue_valid[k], e_valid[k]);
      chk("issue_idx", issue_idx[k], e_idx[k]);
      chk("issue_fu", issue_fu[k], e_fu[k]);
    end
    chk("clear_mask", clear_mask, e_clear);
    if (m_known) begin
      chk("ls_busy", ls_busy, m_busy);
      chk("mult_due", mult_due, e_mdue);
    end
  endtask

  task automatic apply(input logic rst, input logic stall, input logic sq, input logic lsd,
                       input logic [RSLEN-1:0] rdy, input logic [RSLEN-1:0][FU_W-1:0] fu);
    reset       = rst;
    issue_stall = stall;
    squash_flag = sq;
    ls_done     = lsd;
    rs_ready    = rdy;
    rs_fu_type  = fu;
    #1;
    model_eval();
    compare();
  endtask

  task automatic advance();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  logic [RSLEN-1:0][FU_W-1:0] fu_v;
  logic [RSLEN-1:0]           rdy_v;

  initial begin
    @(posedge clock);
    #1;
    fu_v = '0;

    // Reset: outputs held at zero even with every entry ready.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, fu_v);
    chk("rst_clear", clear_mask, 16'h0000);
    chk("rst_valid", issue_valid, 3'b000);
    advance();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, fu_v);
    advance();

    // All ALU ready, full budget: 0,1,2 then 3,4,5.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, fu_v);
    chk("p1_idx0", issue_idx[0], 0);
    chk("p1_idx1", issue_idx[1], 1);
    chk("p1_idx2", issue_idx[2], 2);
    chk("p1_clear", clear_mask, 16'h0007);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, fu_v);
    chk("p2_idx0", issue_idx[0], 3);
    chk("p2_idx2", issue_idx[2], 5);
    advance();

    // Move pointer to 14, then wrap 14,15,0.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, fu_v);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'hC001, fu_v);
    chk("wrap_idx0", issue_idx[0], 14);
    chk("wrap_idx1", issue_idx[1], 15);
    chk("wrap_idx2", issue_idx[2], 0);
    chk("wrap_clear", clear_mask, 16'hC001);
    advance();

    // MULT at entry 2; result due three cycles later and steals a CDB slot.
    fu_v[2] = FU_MULT;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, fu_v);
    chk("mult_clear", clear_mask, 16'h0004);
    chk("mult_fu", issue_fu[0], 1);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, fu_v);
    chk("mult_due_t1", mult_due, 1'b0);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, fu_v);
    chk("mult_due_t2", mult_due, 1'b0);
    advance();
    fu_v = '0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h00E0, fu_v);
    chk("mult_due_t3", mult_due, 1'b1);
    chk("mult_budget_clear", clear_mask, 16'h0060);
    advance();

    // MEM at 4 and 5: one at a time, ls_done frees the unit and trims ALU budget.
    fu_v[4] = FU_MEM;
    fu_v[5] = FU_MEM;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, fu_v);
    chk("mem_first", clear_mask, 16'h0010);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0030, fu_v);
    chk("mem_busy", ls_busy, 1'b1);
    chk("mem_blocked", clear_mask, 16'h0000);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0720, fu_v);
    chk("lsdone_budget", clear_mask, 16'h0300);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, fu_v);
    chk("ls_freed", ls_busy, 1'b0);
    chk("mem_second", clear_mask, 16'h0020);
    advance();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, fu_v);
    advance();

    // Stall: no grants, pointer (6) holds.
    fu_v = '0;
    apply(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, fu_v);
    chk("stall_clear", clear_mask, 16'h0000);
    chk("stall_valid", issue_valid, 3'b000);
    advance();

    // Build ls_busy=1, two mults in flight, pointer 9; then squash.
    fu_v[6] = FU_MEM;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, fu_v);
    chk("stall_ptr_held", clear_mask, 16'h0040);
    advance();
    fu_v[7] = FU_MULT;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0080, fu_v);
    advance();
    fu_v[8] = FU_MULT;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, fu_v);
    advance();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, fu_v);
    chk("squash_clear", clear_mask, 16'h0000);
    chk("squash_busy_before", ls_busy, 1'b1);
    advance();
    fu_v = '0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, fu_v);
    chk("squash_busy_after", ls_busy, 1'b0);
    chk("squash_mult_after", mult_due, 1'b0);
    chk("squash_ptr_idx0", issue_idx[0], 0);
    chk("squash_ptr_idx2", issue_idx[2], 2);
    advance();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int e = 0; e < RSLEN; e++) fu_v[e] = 2'($urandom_range(0, 3));
      rdy_v = 16'($urandom);
      if ($urandom_range(0, 2) == 0) rdy_v = rdy_v & 16'($urandom);
      apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, rdy_v, fu_v);
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
